// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encoding, FSM states, iteration count.
// The ALU control decoder imports the op codes from here so the encoding lives in one place.
package muldiv_pkg;

  localparam logic [5:0] OP_MUL    = 6'b010000;
  localparam logic [5:0] OP_MULH   = 6'b010001;
  localparam logic [5:0] OP_MULHSU = 6'b010010;
  localparam logic [5:0] OP_MULHU  = 6'b010011;
  localparam logic [5:0] OP_DIV    = 6'b010100;
  localparam logic [5:0] OP_DIVU   = 6'b010101;
  localparam logic [5:0] OP_REM    = 6'b010110;
  localparam logic [5:0] OP_REMU   = 6'b010111;

  localparam logic [2:0] OP_GRP_M  = 3'b010;

  localparam int         ITER_CNT  = 32;
  localparam logic [5:0] ITER_LAST = 6'(ITER_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // op[2:0]: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
  function automatic logic op_a_signed(input logic [5:0] op);
    return op[2] ? ~op[0] : (op[1:0] != 2'b11);
  endfunction

  function automatic logic op_b_signed(input logic [5:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling shared by multiply and divide: operand magnitudes on entry,
// conditional two's-complement negation of the raw result on exit.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_a_signed,
  input  logic           i_b_signed,
  input  logic [2*W-1:0] i_val,
  input  logic           i_neg,
  output logic [W-1:0]   o_mag_a,
  output logic [W-1:0]   o_mag_b,
  output logic           o_sign_a,
  output logic           o_sign_b,
  output logic [2*W-1:0] o_val
);

  assign o_sign_a = i_a_signed & i_a[W-1];
  assign o_sign_b = i_b_signed & i_b[W-1];

  assign o_mag_a  = o_sign_a ? -i_a : i_a;
  assign o_mag_b  = o_sign_b ? -i_b : i_b;

  assign o_val    = i_neg ? -i_val : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// 33-cycle latency with a one-cycle fast path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start (blocked while the done pulse is out)
// CALC  | one shift-add / shift-subtract iteration per edge, counter 0..31
// DONE  | result registered; done pulses in the following cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_cnt;
  logic [2:0]          r_fn;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic                r_neg;
  logic [XLEN-1:0]     r_result;
  logic                r_done;

  logic                w_accept;
  logic                w_iter;
  logic                w_last;
  logic                w_fast;
  logic                w_b_zero;
  logic                w_ovf;
  logic [XLEN-1:0]     w_fast_result;

  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_sign_a;
  logic                w_sign_b;
  logic [2*XLEN-1:0]   w_fix_in;
  logic [2*XLEN-1:0]   w_fixed;

  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_div_nxt;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]     w_calc_result;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_signfix #(.W(XLEN)) u_signfix (
    .i_a        (a),
    .i_b        (b),
    .i_a_signed (op_a_signed(op)),
    .i_b_signed (op_b_signed(op)),
    .i_val      (w_fix_in),
    .i_neg      (r_neg),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .o_sign_a   (w_sign_a),
    .o_sign_b   (w_sign_b),
    .o_val      (w_fixed)
  );

  // Special cases that bypass the iterative datapath
  assign w_b_zero = (b == '0);
  assign w_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (b == '1);
  assign w_fast   = op[2] && (w_b_zero || w_ovf);

  always_comb begin
    w_fast_result = '0;
    if (w_b_zero)
      w_fast_result = op[1] ? a : '1;
    else if (w_ovf)
      w_fast_result = op[1] ? '0 : INT_MIN;
  end

  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_diff    = w_rem_sh - {1'b0, r_opnd};
    w_div_nxt = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                             : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    w_acc_nxt = r_fn[2] ? w_div_nxt : w_mul_nxt;
  end

  // Divide feeds only the selected half into the negator; multiply negates the full product
  always_comb begin
    w_fix_in      = w_acc_nxt;
    w_calc_result = w_fixed[2*XLEN-1:XLEN];
    if (r_fn[2]) begin
      w_fix_in      = {{XLEN{1'b0}}, (r_fn[1] ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0])};
      w_calc_result = w_fixed[XLEN-1:0];
    end else if (r_fn[1:0] == 2'b00) begin
      w_calc_result = w_fixed[XLEN-1:0];
    end
  end

  assign w_accept = (r_state == IDLE) && !r_done && start && (op[5:3] == OP_GRP_M);
  assign w_last   = (r_cnt == ITER_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    w_iter = 1'b0;
    case (r_state)
      CALC: begin
        busy   = 1'b1;
        w_iter = 1'b1;
      end
      DONE:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_fn     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_accept) begin
        r_fn  <= op[2:0];
        r_cnt <= '0;
        r_neg <= (op[2] && op[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
        if (op[2]) begin
          r_acc  <= {{XLEN{1'b0}}, w_mag_a};
          r_opnd <= w_mag_b;
        end else begin
          r_acc  <= {{XLEN{1'b0}}, w_mag_b};
          r_opnd <= w_mag_a;
        end
        if (w_fast)
          r_result <= w_fast_result;
      end else if (w_iter) begin
        r_acc <= w_acc_nxt;
        if (w_last) begin
          r_cnt    <= '0;
          r_result <= w_calc_result;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule
